// File: rtl/tsc1_pkg.sv
`default_nettype none
// ============================================================================
// Module      : tsc1_pkg
// Description : Shared state encoding and default configuration constants
//               for the tsc1 triggered sample capture block.
// Revision    : 1.0 - initial release
// ============================================================================
package tsc1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_RUNNING   = 2'b01,
        ST_TRIGGERED = 2'b10,
        ST_BUSY      = 2'b11
    } tsc1_state_e;

    localparam int         DEFAULT_DEPTH    = 32;
    localparam logic [7:0] DEFAULT_TRIG_LVL = 8'd100;

endpackage
`default_nettype wire

// File: rtl/tsc1_adc_model.sv
`default_nettype none
// ============================================================================
// Module      : tsc1_adc_model
// Description : Behavioural ADC stand-in. Returns sample k = k mod 256 one
//               cycle after each request, k counting requests since rst.
// Revision    : 1.0 - initial release
// ============================================================================
module tsc1_adc_model (
    input  logic       clk,
    input  logic       reset,
    input  logic       rst,
    input  logic       req,
    output logic [7:0] sample
);

    logic [7:0] cnt_q;
    logic [7:0] base;

    // A request coinciding with rst is the first request after it (k = 0)
    assign base = rst ? 8'd0 : cnt_q;

    // Request counter and registered sample output
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q  <= 8'd0;
            sample <= 8'd0;
        end else if (req) begin
            sample <= base;
            cnt_q  <= base + 8'd1;
        end else if (rst) begin
            cnt_q  <= 8'd0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/tsc1.sv
`default_nettype none
// ============================================================================
// Module      : tsc1
// Description : Triggered sample capture into a DEPTH-entry ring buffer.
//               Captures until a sample >= TRIG_LVL, then POST more samples.
//               Macro TSC1_READOUT_EN adds a BUSY state that streams the
//               buffer oldest-first on dat_out after capture.
// Revision    : 1.0 - initial release
// ============================================================================
module tsc1
    import tsc1_pkg::*;
#(
    parameter int         DEPTH    = DEFAULT_DEPTH,
    parameter logic [7:0] TRIG_LVL = DEFAULT_TRIG_LVL,
    parameter int         POST     = DEPTH / 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic [1:0]  state_out,
    output logic        req_out,
    output logic        rst_out,
    output logic        rdy_out,
    output logic [7:0]  dat_out,
    output logic [7:0]  buffer_out_tail,
    output logic [7:0]  buffer_out_head,
    output logic [31:0] TRIGTM
);

    localparam int                PTR_W     = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]  PTR_ONE   = PTR_W'(1);
    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(DEPTH - 1);
    localparam logic [31:0]       POST_LAST = 32'(POST) - 32'd1;

    tsc1_state_e       state_q;
    logic              req_q;
    logic              rst_out_q;
    logic              rdy_q;
    logic [31:0]       trigtm_q;
    logic [31:0]       timer_q,    timer_d;
    logic [PTR_W-1:0]  head_q,     head_d;
    logic [PTR_W-1:0]  tail_q,     tail_d;
    logic              full_q,     full_d;
    logic [31:0]       post_cnt_q;
    logic              sample_vld_q;
    logic [7:0]        mem_q [DEPTH];
    logic [7:0]        adc_sample;
    logic              cap;
    logic              trig;
    logic              done;
`ifdef TSC1_READOUT_EN
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W:0]    rd_cnt_q;
    logic [7:0]        dat_q;
`endif

    tsc1_adc_model u_adc (
        .clk    (clk),
        .reset  (reset),
        .rst    (rst_out_q),
        .req    (req_q),
        .sample (adc_sample)
    );

    // A returned sample is stored only while capturing
    assign cap  = sample_vld_q && (state_q == ST_RUNNING || state_q == ST_TRIGGERED);
    assign trig = sample_vld_q && (state_q == ST_RUNNING) && (adc_sample >= TRIG_LVL);
    assign done = (trig && (POST == 0)) ||
                  (sample_vld_q && (state_q == ST_TRIGGERED) && (post_cnt_q == POST_LAST));

    // Ring-buffer pointer and timer advance for each stored sample
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        full_d  = full_q;
        timer_d = timer_q;
        if (cap) begin
            head_d  = head_q + PTR_ONE;
            timer_d = timer_q + 32'd1;
            full_d  = full_q | (head_q == PTR_LAST);
            if (full_q) begin
                tail_d = tail_q + PTR_ONE;
            end
        end
    end

    // Control FSM, buffer storage and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            req_q        <= 1'b0;
            rst_out_q    <= 1'b0;
            rdy_q        <= 1'b0;
            trigtm_q     <= 32'd0;
            timer_q      <= 32'd0;
            head_q       <= '0;
            tail_q       <= '0;
            full_q       <= 1'b0;
            post_cnt_q   <= 32'd0;
            sample_vld_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'd0;
            end
`ifdef TSC1_READOUT_EN
            rd_ptr_q     <= '0;
            rd_cnt_q     <= '0;
            dat_q        <= 8'd0;
`endif
        end else begin
            rst_out_q    <= 1'b0;
            sample_vld_q <= req_q;
            head_q       <= head_d;
            tail_q       <= tail_d;
            full_q       <= full_d;
            timer_q      <= timer_d;
            if (cap) begin
                mem_q[head_q] <= adc_sample;
            end
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        rst_out_q  <= 1'b1;
                        req_q      <= 1'b1;
                        rdy_q      <= 1'b0;
                        head_q     <= '0;
                        tail_q     <= '0;
                        full_q     <= 1'b0;
                        timer_q    <= 32'd0;
                        post_cnt_q <= 32'd0;
                        state_q    <= ST_RUNNING;
                    end
                end
                ST_RUNNING: begin
                    if (trig) begin
                        trigtm_q <= timer_q;
                        state_q  <= ST_TRIGGERED;
                    end
                end
                ST_TRIGGERED: begin
                    if (sample_vld_q) begin
                        post_cnt_q <= post_cnt_q + 32'd1;
                    end
                end
                default: begin
`ifdef TSC1_READOUT_EN
                    if (rd_cnt_q == (PTR_W + 1)'(DEPTH)) begin
                        rdy_q   <= 1'b1;
                        state_q <= ST_IDLE;
                    end else begin
                        dat_q    <= mem_q[rd_ptr_q];
                        rd_ptr_q <= rd_ptr_q + PTR_ONE;
                        rd_cnt_q <= rd_cnt_q + 1'b1;
                    end
`else
                    state_q <= ST_IDLE;
`endif
                end
            endcase
            // Completion overrides the per-state transition above
            if (done) begin
                req_q <= 1'b0;
`ifdef TSC1_READOUT_EN
                state_q  <= ST_BUSY;
                rd_ptr_q <= tail_d;
                rd_cnt_q <= '0;
`else
                state_q  <= ST_IDLE;
                rdy_q    <= 1'b1;
`endif
            end
        end
    end

    assign state_out       = state_q;
    assign req_out         = req_q;
    assign rst_out         = rst_out_q;
    assign rdy_out         = rdy_q;
    assign TRIGTM          = trigtm_q;
    assign buffer_out_tail = mem_q[tail_q];
    assign buffer_out_head = mem_q[head_q - PTR_ONE];
`ifdef TSC1_READOUT_EN
    assign dat_out         = dat_q;
`else
    assign dat_out         = 8'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_tsc1.sv
`default_nettype none
// ============================================================================
// Module      : tb_tsc1
// Description : Directed self-checking bench for tsc1 with default parameters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_tsc1;

    logic        clk;
    logic        reset;
    logic        start;
    logic [1:0]  state_out;
    logic        req_out;
    logic        rst_out;
    logic        rdy_out;
    logic [7:0]  dat_out;
    logic [7:0]  buffer_out_tail;
    logic [7:0]  buffer_out_head;
    logic [31:0] TRIGTM;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int cyc0   = 0;

    tsc1 dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .state_out       (state_out),
        .req_out         (req_out),
        .rst_out         (rst_out),
        .rdy_out         (rdy_out),
        .dat_out         (dat_out),
        .buffer_out_tail (buffer_out_tail),
        .buffer_out_head (buffer_out_head),
        .TRIGTM          (TRIGTM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Pulse start for one edge; cyc0 marks the accepting edge
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc0 = cyc;
    endtask

    task automatic wait_state(input logic [1:0] s, input int bound);
        int n = 0;
        while (state_out !== s && n < bound) begin
            tick();
            n++;
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"}, 32'(state_out), 32'd0);
        chk({tag, "_req"},   32'(req_out),   32'd0);
        chk({tag, "_rst"},   32'(rst_out),   32'd0);
        chk({tag, "_rdy"},   32'(rdy_out),   32'd0);
        chk({tag, "_dat"},   32'(dat_out),   32'd0);
        chk({tag, "_trig"},  TRIGTM,         32'd0);
        chk({tag, "_head"},  32'(buffer_out_head), 32'd0);
        chk({tag, "_tail"},  32'(buffer_out_tail), 32'd0);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        start = 1'b0;
        repeat (3) tick();
        check_reset_vals("rst_hold");
        reset = 1'b1;
        repeat (2) tick();
        check_reset_vals("idle");

        // Start: rst_out one cycle, RUNNING, req_out continuous
        pulse_start();
        chk("start_rst_out", 32'(rst_out),   32'd1);
        chk("start_state",   32'(state_out), 32'd1);
        chk("start_req",     32'(req_out),   32'd1);
        chk("start_rdy",     32'(rdy_out),   32'd0);
        tick();
        chk("run_rst_out",   32'(rst_out),   32'd0);
        chk("run_req",       32'(req_out),   32'd1);
        // Start during RUNNING must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ign_rst_out",   32'(rst_out),   32'd0);
        chk("ign_state",     32'(state_out), 32'd1);
        chk("ign_req",       32'(req_out),   32'd1);

        // Sample k is stored at edge k+2 after start; trigger on 0x64
        wait_state(2'b10, 300);
        chk("trig_cycle", 32'(cyc - cyc0), 32'd102);
        chk("trig_state", 32'(state_out),  32'd2);
        chk("trig_tm",    TRIGTM,          32'd100);
        chk("trig_head",  32'(buffer_out_head), 32'h64);
        chk("trig_req",   32'(req_out),    32'd1);

        // 16 post samples: 0x65..0x74, buffer holds 0x55..0x74
        n = 0;
        while (req_out !== 1'b0 && n < 100) begin
            tick();
            n++;
        end
        chk("done_cycle", 32'(cyc - cyc0), 32'd118);
        chk("done_head",  32'(buffer_out_head), 32'h74);
        chk("done_tail",  32'(buffer_out_tail), 32'h55);
        chk("done_req",   32'(req_out),    32'd0);
        chk("done_tm",    TRIGTM,          32'd100);
`ifdef TSC1_READOUT_EN
        chk("done_state", 32'(state_out),  32'd3);
        chk("done_rdy",   32'(rdy_out),    32'd0);
        for (int i = 0; i < 32; i++) begin
            tick();
            chk("rd_dat",   32'(dat_out),   32'(8'h55 + i));
            chk("rd_state", 32'(state_out), 32'd3);
        end
        tick();
        chk("rd_end_state", 32'(state_out), 32'd0);
        chk("rd_end_rdy",   32'(rdy_out),   32'd1);
`else
        chk("done_state", 32'(state_out),  32'd0);
        chk("done_rdy",   32'(rdy_out),    32'd1);
        chk("done_dat",   32'(dat_out),    32'd0);
`endif
        // rdy stays high while idle
        repeat (3) tick();
        chk("idle_rdy", 32'(rdy_out), 32'd1);

        // Accepted start clears rdy; then abort with reset in TRIGGERED
        pulse_start();
        chk("s2_rdy",   32'(rdy_out),   32'd0);
        chk("s2_state", 32'(state_out), 32'd1);
        wait_state(2'b10, 300);
        chk("s2_trig_cycle", 32'(cyc - cyc0), 32'd102);
        repeat (4) tick();
        chk("s2_in_trig", 32'(state_out), 32'd2);
        reset = 1'b0;
        #1;
        check_reset_vals("abort");
        repeat (2) tick();
        reset = 1'b1;
        tick();

        // Capture repeats identically after the abort
        pulse_start();
        chk("s3_state", 32'(state_out), 32'd1);
        wait_state(2'b10, 300);
        chk("s3_trig_cycle", 32'(cyc - cyc0), 32'd102);
        chk("s3_trig_tm",    TRIGTM,          32'd100);
        chk("s3_head",       32'(buffer_out_head), 32'h64);
        chk("s3_tail",       32'(buffer_out_tail), 32'h45);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
